// File: rtl/mem_access_arbiter_pkg.sv
// Shared definitions for the memory access arbiter: default widths, the
// write/read encoding of the we inputs, and the sequencer state type.
package mem_ctrl_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 2;

  localparam logic WRITE = 1'b1;
  localparam logic READ  = 1'b0;

  // SETUP/HOLD bracket the one-cycle STROBE so the latch memory sees
  // addr and data stable on both sides of the store pulse.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    SAMPLE = 3'd4
  } state_t;

endpackage

// File: rtl/mem_access_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the latch memory.
//   req*/we*/addr*/wdata*  requester transaction inputs
//   ack*/rdata             completion pulse and read result
//   mem_data/store/addr    drive the memory system; mem_q is its output
//   busy/grant_id          arbiter status
// slave  : the arbiter's view; master : the requester/memory side view.
interface mem_access_arbiter_if
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic              req0, we0, ack0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              req1, we1, ack1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] mem_data;
  logic              mem_store;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_q;
  logic              busy;
  logic              grant_id;

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_q,
    output ack0, ack1, rdata, mem_data, mem_store, mem_addr, busy, grant_id
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_q,
    input  ack0, ack1, rdata, mem_data, mem_store, mem_addr, busy, grant_id
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
//   clk, reset_n  clock and synchronous active-low reset
//   req[1:0]      request vector
//   advance       commit the current grant (IDLE->SETUP edge)
//   grant[1:0]    one-hot winner (all zero when no request)
//   grant_idx     index of the winner
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       grant_idx
);

  // Resets to 1 so requester 0 wins the first tie.
  logic r_last_grant;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = r_last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    grant_idx = grant[1];
  end

  // NOTE: clocked state uses non-blocking assignment so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n)     r_last_grant <= 1'b1;
    else if (advance) r_last_grant <= grant_idx;
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares the 4 x 8-bit latch memory between two requesters.
//   clk, reset_n  clock and synchronous active-low reset
//   bus           requester handshakes, memory drive/sample, status
// Writes run IDLE->SETUP->STROBE->HOLD (ack in HOLD); reads run
// IDLE->SETUP->SAMPLE (ack and rdata in SAMPLE).
module mem_access_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic                  clk,
  input logic                  reset_n,
  mem_access_arbiter_if.slave  bus
);

  state_t            r_state, w_next_state;
  logic              r_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_data;
  logic [DATA_W-1:0] r_rdata;
  logic              r_mem_store;
  logic              r_grant_id;

  logic [1:0] w_req, w_grant;
  logic       w_grant_idx, w_advance, w_ack;

  assign w_req     = {bus.req1, bus.req0};
  assign w_advance = (r_state == IDLE) && (w_req != 2'b00);

  rr_arbiter2 u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (w_req),
    .advance   (w_advance),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  always_comb begin
    w_next_state = r_state;
    w_ack        = 1'b0;
    case (r_state)
      IDLE:    if (w_advance) w_next_state = SETUP;
      SETUP:   w_next_state = (r_we == WRITE) ? STROBE : SAMPLE;
      STROBE:  w_next_state = HOLD;
      HOLD:    begin w_ack = 1'b1; w_next_state = IDLE; end
      SAMPLE:  begin w_ack = 1'b1; w_next_state = IDLE; end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_we        <= READ;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_rdata     <= '0;
      r_mem_store <= 1'b0;
      r_grant_id  <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      // Registered from the next state so the store pulse is glitch-free.
      r_mem_store <= (w_next_state == STROBE);
      // The winner's request is captured once; later input changes are ignored.
      if (w_advance) begin
        r_grant_id <= w_grant_idx;
        r_we       <= w_grant[1] ? bus.we1    : bus.we0;
        r_mem_addr <= w_grant[1] ? bus.addr1  : bus.addr0;
        r_mem_data <= w_grant[1] ? bus.wdata1 : bus.wdata0;
      end
      // mem_q has settled on the registered address during SETUP; capturing
      // it here makes rdata valid alongside ack in SAMPLE.
      if (r_state == SETUP && r_we == READ) r_rdata <= bus.mem_q;
    end
  end

  assign bus.ack0      = w_ack & ~r_grant_id;
  assign bus.ack1      = w_ack &  r_grant_id;
  assign bus.rdata     = r_rdata;
  assign bus.mem_data  = r_mem_data;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_store = r_mem_store;
  assign bus.busy      = (r_state != IDLE);
  assign bus.grant_id  = r_grant_id;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter: directed scenarios followed by
// randomized single and contended traffic, checked against a reference
// memory image and a round-robin grant model.
module tb_mem_access_arbiter;
  import mem_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mem_access_arbiter_if #(.DATA_W(8), .ADDR_W(2)) bus ();

  mem_access_arbiter #(.DATA_W(8), .ADDR_W(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Memory system: the store pulse captures data; output follows addr.
  logic [7:0] mem [4];
  always @(posedge clk) if (bus.mem_store) mem[bus.mem_addr] <= bus.mem_data;
  assign bus.mem_q = mem[bus.mem_addr];

  // Reference model state.
  logic [7:0] ref_mem [4];
  bit         m_last;
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit id, input bit req, input bit we,
                       input logic [1:0] a, input logic [7:0] d);
    if (id) begin bus.req1 = req; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; end
    else    begin bus.req0 = req; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(0, 0, 0, 2'd0, 8'h00);
    drive(1, 0, 0, 2'd0, 8'h00);
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_store", bus.mem_store, 0);
    check("rst_acks", {bus.ack1, bus.ack0}, 0);
    check("rst_grant", bus.grant_id, 0);
    reset_n = 1'b1;
    m_last  = 1'b1;
  endtask

  // Single-requester transaction, started from an IDLE cycle's negedge.
  // With scramble set, the requester changes addr/wdata right after grant.
  task automatic txn(input bit id, input bit we, input logic [1:0] a,
                     input logic [7:0] d, input bit scramble);
    int lat = 0, stores = 0, store_at = 0;
    bit got = 0;
    drive(id, 1, we, a, d);
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (scramble && lat == 1) drive(id, 1, we, a + 2'd2, 8'hFF);
      check("addr_stable", bus.mem_addr, a);
      check("grant_id", bus.grant_id, id);
      if (we) check("data_stable", bus.mem_data, d);
      if (bus.mem_store) begin stores++; store_at = lat; end
      check("no_wrong_ack", id ? bus.ack0 : bus.ack1, 0);
      if (id ? bus.ack1 : bus.ack0) got = 1;
    end
    check("ack_latency", lat, we ? 3 : 2);
    if (we) begin
      check("store_count", stores, 1);
      check("store_cycle", store_at, 2);
      ref_mem[a] = d;
    end else begin
      check("store_count", stores, 0);
      check("rdata", bus.rdata, ref_mem[a]);
    end
    m_last = id;
    drive(id, 0, we, a, d);
    @(negedge clk);
    check("back_idle", bus.busy, 0);
  endtask

  // Both requesters held high; each ack reloads that requester's fields.
  task automatic contend(input int n);
    bit         p_we [2];
    logic [1:0] p_a  [2];
    logic [7:0] p_d  [2];
    bit         exp_id;
    for (int k = 0; k < 2; k++) begin
      p_we[k] = 1'($urandom_range(0, 1));
      p_a[k]  = 2'($urandom_range(0, 3));
      p_d[k]  = 8'($urandom);
      drive(1'(k), 1, p_we[k], p_a[k], p_d[k]);
    end
    for (int t = 0; t < n; t++) begin
      int cyc = 0;
      bit got = 0;
      exp_id = ~m_last;
      while (!got && cyc < 8) begin
        @(negedge clk);
        cyc++;
        check("ack_exclusive", bus.ack0 & bus.ack1, 0);
        if (bus.ack0 | bus.ack1) begin
          got = 1;
          check("rr_order", bus.ack1, exp_id);
          if (p_we[exp_id]) ref_mem[p_a[exp_id]] = p_d[exp_id];
          else check("rr_rdata", bus.rdata, ref_mem[p_a[exp_id]]);
          m_last = exp_id;
          p_we[exp_id] = 1'($urandom_range(0, 1));
          p_a[exp_id]  = 2'($urandom_range(0, 3));
          p_d[exp_id]  = 8'($urandom);
          drive(exp_id, 1, p_we[exp_id], p_a[exp_id], p_d[exp_id]);
        end
      end
      check("rr_ack_seen", got, 1);
    end
    drive(0, 0, 0, 2'd0, 8'h00);
    drive(1, 0, 0, 2'd0, 8'h00);
    @(negedge clk);
    check("rr_idle", bus.busy, 0);
  endtask

  initial begin
    logic [1:0] hold_addr;
    logic [7:0] hold_data;
    bit         stray;

    // Reset state.
    do_reset();
    @(negedge clk);
    check("rst_rdata", bus.rdata, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_data", bus.mem_data, 0);

    // Write then read back through the other requester.
    txn(0, WRITE, 2'd2, 8'hA5, 0);
    txn(1, READ,  2'd2, 8'h00, 0);

    // Fill every address, then read all back.
    for (int i = 0; i < 4; i++) txn(0, WRITE, 2'(i), 8'(8'h11 * (i + 1)), 0);
    for (int i = 0; i < 4; i++) txn(1, READ, 2'(i), 8'h00, 0);

    // Contention straight after reset: first grant to requester 0.
    do_reset();
    contend(12);

    // Idle period: nothing moves.
    hold_addr = bus.mem_addr;
    hold_data = bus.mem_data;
    stray     = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.busy || bus.mem_store || bus.ack0 || bus.ack1 ||
          bus.mem_addr !== hold_addr || bus.mem_data !== hold_data) stray = 1;
    end
    check("idle_quiet", stray, 0);

    // Inputs changed after grant are ignored.
    txn(1, WRITE, 2'd1, 8'h5A, 1);
    txn(0, READ,  2'd3, 8'h00, 0);
    txn(0, READ,  2'd1, 8'h00, 0);

    // Reset during STROBE: byte keeps the latched data, no ack.
    drive(0, 1, WRITE, 2'd0, 8'hC3);
    repeat (2) @(negedge clk);
    check("pre_rst_strobe", bus.mem_store, 1);
    reset_n = 1'b0;
    drive(0, 0, WRITE, 2'd0, 8'hC3);
    @(negedge clk);
    check("abort_busy", bus.busy, 0);
    check("abort_store", bus.mem_store, 0);
    check("abort_acks", {bus.ack1, bus.ack0}, 0);
    check("abort_rdata", bus.rdata, 0);
    reset_n = 1'b1;
    m_last  = 1'b1;
    ref_mem[0] = 8'hC3;
    @(negedge clk);
    check("abort_no_late_ack", {bus.ack1, bus.ack0}, 0);
    txn(1, READ, 2'd0, 8'h00, 0);

    // Randomized single-requester traffic.
    for (int i = 0; i < 24; i++)
      txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom_range(0, 1)));

    // Randomized contended traffic.
    contend(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
